mash_ncl: RTL and testbench



---
 rtl/mash_ncl_pkg.sv | 10 +
 rtl/mash_ncl_if.sv | 24 ++
 rtl/mash_ncl_diff.sv | 30 +++
 rtl/mash_ncl.sv | 150 +++++++++++++++
 tb/tb_mash_ncl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/mash_ncl_pkg.sv
// Shared widths and types for the MASH noise-cancellation stage.
package mash_pkg;

  localparam int Y_W      = 4;
  localparam int FILL_3RD = 2;
  localparam int FILL_2ND = 1;

  typedef logic signed [Y_W-1:0] y_t;

endpackage

// File: rtl/mash_ncl_if.sv
// Sample-side handshake between the sdm_sec cascade/controller and mash_ncl.
interface mash_ncl_if #(
  parameter int NW = 8
);
  logic          en;
  logic          clr;
  logic [1:0]    c1;
  logic [1:0]    c2;
  logic [1:0]    c3;
  logic [NW-1:0] n_int;
  logic [NW-1:0] div_n;
  logic          div_vld;
  logic          sat;

  modport master (
    output en, clr, c1, c2, c3, n_int,
    input  div_n, div_vld, sat
  );

  modport slave (
    input  en, clr, c1, c2, c3, n_int,
    output div_n, div_vld, sat
  );
endinterface

// File: rtl/mash_ncl_diff.sv
// Enable-qualified one-sample delay with clear; the current value is x_i itself,
// dly_o is the previous accepted sample and diff_o their first difference.
module mash_diff #(
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] dly_o,
  output logic signed [W:0]   diff_o
);

  logic signed [W-1:0] x_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
    end else if (en_i) begin
      x_q <= x_i;
    end
  end

  assign dly_o  = x_q;
  assign diff_o = (W+1)'(x_i) - (W+1)'(x_q);

endmodule

// File: rtl/mash_ncl.sv
// MASH noise cancellation plus saturated modulus register for the fractional-N divider.
// Define MASH_THIRD_STAGE_EN for the 1-1-1 (3rd-order) form; otherwise 1-1 (2nd-order).
module mash_ncl
  import mash_pkg::*;
#(
  parameter int NW   = 8,
  parameter int NMIN = 4
) (
  input logic       clk,
  input logic       rst,
  mash_ncl_if.slave bus
);

  localparam logic signed [NW+1:0] S_MAX   = (NW+2)'((1 << NW) - 1);
  localparam logic signed [NW+1:0] S_MIN   = (NW+2)'(NMIN);
  localparam logic [NW-1:0]        DIV_RST = NW'(NMIN);

  logic signed [1:0] c1_s;
  logic signed [1:0] c2_s;
  y_t                y;
  logic              unused_bits;

  assign c1_s = {1'b0, bus.c1[0]};
  assign c2_s = {1'b0, bus.c2[0]};

`ifdef MASH_THIRD_STAGE_EN
  localparam logic [1:0] FILL_MAX = 2'(FILL_3RD);

  logic signed [1:0] c3_s;
  logic signed [1:0] c1_d1_q, c1_d2_q;
  logic signed [1:0] c2_d1, c2_d2, c3_d1;
  logic signed [2:0] dc2_n, dc2_n1, dc3_n, dc3_n1;
  logic signed [3:0] ddc3;

  assign c3_s = {1'b0, bus.c3[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_d1_q <= '0;
      c1_d2_q <= '0;
    end else if (bus.clr) begin
      c1_d1_q <= '0;
      c1_d2_q <= '0;
    end else if (bus.en) begin
      c1_d1_q <= c1_s;
      c1_d2_q <= c1_d1_q;
    end
  end

  // c2 needs its difference one sample late, so it runs through a second delay.
  mash_diff #(.W(2)) u_c2a (
    .clk(clk), .rst(rst), .en_i(bus.en), .clr_i(bus.clr),
    .x_i(c2_s), .dly_o(c2_d1), .diff_o(dc2_n)
  );
  mash_diff #(.W(2)) u_c2b (
    .clk(clk), .rst(rst), .en_i(bus.en), .clr_i(bus.clr),
    .x_i(c2_d1), .dly_o(c2_d2), .diff_o(dc2_n1)
  );

  // Second difference of c3 as the difference of its first difference.
  mash_diff #(.W(2)) u_c3a (
    .clk(clk), .rst(rst), .en_i(bus.en), .clr_i(bus.clr),
    .x_i(c3_s), .dly_o(c3_d1), .diff_o(dc3_n)
  );
  mash_diff #(.W(3)) u_c3b (
    .clk(clk), .rst(rst), .en_i(bus.en), .clr_i(bus.clr),
    .x_i(dc3_n), .dly_o(dc3_n1), .diff_o(ddc3)
  );

  assign y = Y_W'(c1_d2_q) + Y_W'(dc2_n1) + Y_W'(ddc3);

  assign unused_bits = ^{bus.c1[1], bus.c2[1], bus.c3[1], dc2_n, c2_d2, c3_d1, dc3_n1};
`else
  localparam logic [1:0] FILL_MAX = 2'(FILL_2ND);

  logic signed [1:0] c1_d1_q;
  logic signed [1:0] c2_d1;
  logic signed [2:0] dc2_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_d1_q <= '0;
    end else if (bus.clr) begin
      c1_d1_q <= '0;
    end else if (bus.en) begin
      c1_d1_q <= c1_s;
    end
  end

  mash_diff #(.W(2)) u_c2a (
    .clk(clk), .rst(rst), .en_i(bus.en), .clr_i(bus.clr),
    .x_i(c2_s), .dly_o(c2_d1), .diff_o(dc2_n)
  );

  assign y = Y_W'(c1_d1_q) + Y_W'(dc2_n);

  assign unused_bits = ^{bus.c1[1], bus.c2[1], bus.c3, c2_d1};
`endif

  logic signed [NW+1:0] s;
  logic [NW-1:0]        div_n_d, div_n_q;
  logic                 sat_d, sat_q;
  logic                 div_vld_q;
  logic [1:0]           fill_q;

  // Two guard bits keep n_int + y exact before clamping.
  assign s = signed'({2'b00, bus.n_int}) + (NW+2)'(y);

  always_comb begin
    div_n_d = s[NW-1:0];
    sat_d   = 1'b0;
    if (s > S_MAX) begin
      div_n_d = '1;
      sat_d   = 1'b1;
    end else if (s < S_MIN) begin
      div_n_d = DIV_RST;
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q    <= '0;
      div_n_q   <= DIV_RST;
      sat_q     <= 1'b0;
      div_vld_q <= 1'b0;
    end else if (bus.clr) begin
      fill_q    <= '0;
      div_n_q   <= DIV_RST;
      sat_q     <= 1'b0;
      div_vld_q <= 1'b0;
    end else if (bus.en) begin
      if (fill_q == FILL_MAX) begin
        div_n_q   <= div_n_d;
        sat_q     <= sat_d;
        div_vld_q <= 1'b1;
      end else begin
        fill_q    <= fill_q + 2'd1;
        div_vld_q <= 1'b0;
      end
    end else begin
      div_vld_q <= 1'b0;
    end
  end

  assign bus.div_n   = div_n_q;
  assign bus.sat     = sat_q;
  assign bus.div_vld = div_vld_q;

endmodule

// File: tb/tb_mash_ncl.sv
// Directed bench for mash_ncl; expectations cover both the 3rd-order and 2nd-order builds.
module tb_mash_ncl;

`ifdef MASH_THIRD_STAGE_EN
  localparam bit THIRD = 1'b1;
`else
  localparam bit THIRD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mash_ncl_if #(.NW(8)) bus ();

  mash_ncl #(.NW(8), .NMIN(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp))
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int v, input int n, input int s);
    chk({tag, ".vld"}, 32'(bus.div_vld), v);
    chk({tag, ".div_n"}, 32'(bus.div_n), n);
    chk({tag, ".sat"}, 32'(bus.sat), s);
  endtask

  task automatic smp(input logic e, input logic c, input logic [1:0] a1, input logic [1:0] a2,
                     input logic [1:0] a3, input logic [7:0] n);
    bus.en    = e;
    bus.clr   = c;
    bus.c1    = a1;
    bus.c2    = a2;
    bus.c3    = a3;
    bus.n_int = n;
    @(posedge clk);
    #1;
    $display("txn en=%0d clr=%0d c1=%0d c2=%0d c3=%0d n_int=%0d -> div_n=%0d vld=%0d sat=%0d",
             e, c, a1, a2, a3, n, bus.div_n, bus.div_vld, bus.sat);
  endtask

  // One transaction, then check against the expectation for the active build.
  task automatic run(input string tag, input logic e, input logic c, input logic [1:0] a1,
                     input logic [1:0] a2, input logic [1:0] a3, input logic [7:0] n,
                     input int v3, input int n3, input int s3,
                     input int v2, input int n2, input int s2);
    smp(e, c, a1, a2, a3, n);
    if (THIRD) expect_out(tag, v3, n3, s3);
    else       expect_out(tag, v2, n2, s2);
  endtask

  initial begin
    int imp3[4];
    imp3 = '{21, 18, 21, 20};

    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.clr   = 1'b0;
    bus.c1    = 2'd0;
    bus.c2    = 2'd0;
    bus.c3    = 2'd0;
    bus.n_int = 8'd20;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 4, 0);
    rst = 1'b0;

    // Zero carries: first valid after the fill threshold.
    for (int k = 1; k <= 4; k++) begin
      run($sformatf("zero%0d", k), 1, 0, 0, 0, 0, 20,
          (k >= 3) ? 1 : 0, (k >= 3) ? 20 : 4, 0,
          (k >= 2) ? 1 : 0, (k >= 2) ? 20 : 4, 0);
    end
    run("idle", 0, 0, 0, 0, 0, 20, 0, 20, 0, 0, 20, 0);

    // clr wins over en; then constant c1 (bit 1 set must be ignored).
    run("clr_d", 1, 1, 2'b11, 0, 0, 20, 0, 4, 0, 0, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      run($sformatf("c1const%0d", k), 1, 0, 2'b11, 2'b10, 0, 20,
          (k >= 3) ? 1 : 0, (k >= 3) ? 21 : 4, 0,
          (k >= 2) ? 1 : 0, (k >= 2) ? 21 : 4, 0);
    end

    // c3 impulse after two zero samples.
    run("clr_e", 0, 1, 0, 0, 0, 20, 0, 4, 0, 0, 4, 0);
    run("imp_f1", 1, 0, 0, 0, 0, 20, 0, 4, 0, 0, 4, 0);
    run("imp_f2", 1, 0, 0, 0, 0, 20, 0, 4, 0, 1, 20, 0);
    for (int k = 0; k < 4; k++) begin
      run($sformatf("imp%0d", k), 1, 0, 0, 0, (k == 0) ? 2'd1 : 2'd0, 20,
          1, imp3[k], 0, 1, 20, 0);
    end

    // c2 = 1,0 sequence; c3 toggles in the 2nd-order build.
    run("clr_f", 1, 1, 0, 0, 0, 20, 0, 4, 0, 0, 4, 0);
    run("c2_1", 1, 0, 0, 0, THIRD ? 2'd0 : 2'd1, 20, 0, 4, 0, 0, 4, 0);
    run("c2_2", 1, 0, 0, 1, 0, 20, 0, 4, 0, 1, 21, 0);
    run("c2_3", 1, 0, 0, 0, THIRD ? 2'd0 : 2'd1, 20, 1, 21, 0, 1, 19, 0);
    run("c2_4", 1, 0, 0, 0, 0, 20, 1, 19, 0, 1, 20, 0);

    // Upper clamp at 255, then the exact 255 boundary.
    run("clr_g", 1, 1, 0, 0, 0, 255, 0, 4, 0, 0, 4, 0);
    run("hi_1", 1, 0, 1, 0, 1, 255, 0, 4, 0, 0, 4, 0);
    run("hi_2", 1, 0, 0, 1, 0, 255, 0, 4, 0, 1, 255, 1);
    run("hi_3", 1, 0, 0, 0, 1, 255, 1, 255, 1, 1, 254, 0);
    run("hi_4", 1, 0, 0, 0, 0, 255, 1, 252, 0, 1, 255, 0);

    // Lower clamp at NMIN, held through an idle cycle.
    run("clr_h", 1, 1, 0, 0, 0, 5, 0, 4, 0, 0, 4, 0);
    run("lo_1", 1, 0, 0, 1, 0, 5, 0, 4, 0, 0, 4, 0);
    run("lo_2", 1, 0, 0, 0, 1, 5, 0, 4, 0, 1, 4, 0);
    run("lo_3", 1, 0, 0, 0, 0, 5, 1, 4, 1, 1, 5, 0);
    run("lo_idle", 0, 0, 0, 0, 0, 5, 0, 4, 1, 0, 5, 0);
    run("lo_4", 1, 0, 0, 0, 0, 5, 1, 6, 0, 1, 5, 0);

    // Asynchronous reset mid-cycle, then refill.
    #2;
    rst = 1'b1;
    #1;
    expect_out("rst_async", 0, 4, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("post_rst1", 1, 0, 1, 0, 0, 20, 0, 4, 0, 0, 4, 0);
    run("post_rst2", 1, 0, 1, 0, 0, 20, 0, 4, 0, 1, 21, 0);
    run("post_rst3", 1, 0, 1, 0, 0, 20, 1, 21, 0, 1, 21, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
